// File: rtl/anode_scan.sv
// Time-multiplexed anode scanner for an 8-digit seven-segment display.
// Double-buffered value/enable/dp sets; encoded leads anode/dp_n by one cycle.
module anode_scan #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] value,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_in,
  input  logic        load,
  output logic [3:0]  encoded,
  output logic        dp_n,
  output logic [7:0]  anode,
  output logic        frame_start
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   pend_val;
  logic [7:0]    pend_en;
  logic [7:0]    pend_dp;
  logic [31:0]   act_val;
  logic [7:0]    act_en;
  logic [7:0]    act_dp;

  logic          tc;
  logic          copy;
  logic          past_blank;
  logic          lit;
  logic [CW-1:0] cnt_next;
  logic [2:0]    idx_next;
  logic [31:0]   act_val_next;
  logic [7:0]    act_en_next;
  logic [7:0]    act_dp_next;
  logic [7:0]    anode_next;
  logic          dp_n_next;

  // With no blanking every cycle of the slot is lit; avoids an always-true compare.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign past_blank = 1'b1;
    end else begin : g_blank
      assign past_blank = (cnt >= CW'(BLANK_CYCLES));
    end
  endgenerate

  // Next-state for slot counter, digit index and frame-boundary copy.
  always_comb begin
    tc           = (cnt == LAST);
    copy         = tc && (idx == 3'd7);
    cnt_next     = tc ? {CW{1'b0}} : (cnt + CW'(1));
    idx_next     = tc ? (idx + 3'd1) : idx;
    act_val_next = copy ? pend_val : act_val;
    act_en_next  = copy ? pend_en  : act_en;
    act_dp_next  = copy ? pend_dp  : act_dp;
  end

  // Anode/dp from the current (already-registered) state: this is the one-cycle lag behind encoded.
  always_comb begin
    lit = act_en[idx] && past_blank;
    if (lit) begin
      anode_next = ~(8'h01 << idx);
      dp_n_next  = ~act_dp[idx];
    end else begin
      anode_next = 8'hFF;
      dp_n_next  = 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt         <= {CW{1'b0}};
      idx         <= 3'd0;
      pend_val    <= 32'h0;
      pend_en     <= 8'h00;
      pend_dp     <= 8'h00;
      act_val     <= 32'h0;
      act_en      <= 8'h00;
      act_dp      <= 8'h00;
      encoded     <= 4'h0;
      anode       <= 8'hFF;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      idx         <= idx_next;
      act_val     <= act_val_next;
      act_en      <= act_en_next;
      act_dp      <= act_dp_next;
      // pending takes new inputs even on a copy edge; active gets the old pending
      if (load) begin
        pend_val <= value;
        pend_en  <= digit_en;
        pend_dp  <= dp_in;
      end else begin
        pend_val <= pend_val;
        pend_en  <= pend_en;
        pend_dp  <= pend_dp;
      end
      encoded     <= act_val_next[{idx_next, 2'b00} +: 4];
      anode       <= anode_next;
      dp_n        <= dp_n_next;
      frame_start <= copy;
    end
  end

endmodule

// File: tb/tb_anode_scan.sv
// Directed bench for anode_scan with REFRESH_DIV=4: one DUT with BLANK_CYCLES=1, one with 0.
module tb_anode_scan;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [31:0] value;
  logic [7:0]  digit_en;
  logic [7:0]  dp_in;
  logic        load;
  logic [3:0]  encoded,  encoded0;
  logic        dp_n,     dp_n0;
  logic [7:0]  anode,    anode0;
  logic        frame_start, frame_start0;

  int n_tests = 0;
  int n_fail  = 0;

  anode_scan #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .value(value), .digit_en(digit_en), .dp_in(dp_in),
    .load(load), .encoded(encoded), .dp_n(dp_n), .anode(anode), .frame_start(frame_start)
  );

  anode_scan #(.REFRESH_DIV(4), .BLANK_CYCLES(0)) dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .value(value), .digit_en(digit_en), .dp_in(dp_in),
    .load(load), .encoded(encoded0), .dp_n(dp_n0), .anode(anode0), .frame_start(frame_start0)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Checks one 32-cycle frame starting at the cycle with cnt=0, idx=0.
  // pen/pdp are the enable/dp sets that were active in the preceding cycle (frame j=0 lag).
  task automatic run_frame(input string tag, input logic [31:0] v, input logic [7:0] en,
                           input logic [7:0] dp, input logic [7:0] pen, input logic [7:0] pdp,
                           input logic fs0, input int ld_j, input logic [31:0] lv,
                           input logic [7:0] le, input logic [7:0] ldp);
    int d, c;
    logic [7:0] cen, cdp, an_exp, an0_exp;
    logic [3:0] enc_exp;
    logic lit, lit0, dp_exp, dp0_exp, fs_exp;
    for (int j = 0; j < 32; j++) begin
      d   = ((j + 31) % 32) / 4;
      c   = (j + 31) % 4;
      cen = (j == 0) ? pen : en;
      cdp = (j == 0) ? pdp : dp;
      lit  = cen[d] && (c >= 1);
      lit0 = cen[d];
      an_exp  = lit  ? ~(8'h01 << d) : 8'hFF;
      an0_exp = lit0 ? ~(8'h01 << d) : 8'hFF;
      dp_exp  = lit  ? ~cdp[d] : 1'b1;
      dp0_exp = lit0 ? ~cdp[d] : 1'b1;
      enc_exp = v[(j / 4) * 4 +: 4];
      fs_exp  = (j == 0) ? fs0 : 1'b0;
      n_tests += 7;
      if (encoded !== enc_exp) begin
        n_fail++; $display("FAIL %s encoded j=%0d got %h want %h", tag, j, encoded, enc_exp);
      end
      if (encoded0 !== enc_exp) begin
        n_fail++; $display("FAIL %s encoded0 j=%0d got %h want %h", tag, j, encoded0, enc_exp);
      end
      if (anode !== an_exp) begin
        n_fail++; $display("FAIL %s anode j=%0d got %h want %h", tag, j, anode, an_exp);
      end
      if (anode0 !== an0_exp) begin
        n_fail++; $display("FAIL %s anode_blank0 j=%0d got %h want %h", tag, j, anode0, an0_exp);
      end
      if (dp_n !== dp_exp) begin
        n_fail++; $display("FAIL %s dp_n j=%0d got %b want %b", tag, j, dp_n, dp_exp);
      end
      if (dp_n0 !== dp0_exp) begin
        n_fail++; $display("FAIL %s dp_n_blank0 j=%0d got %b want %b", tag, j, dp_n0, dp0_exp);
      end
      if (frame_start !== fs_exp) begin
        n_fail++; $display("FAIL %s frame_start j=%0d got %b want %b", tag, j, frame_start, fs_exp);
      end
      if (j == ld_j) begin
        value = lv; digit_en = le; dp_in = ldp; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick();
      load = 1'b0;
      value = 32'hDEAD_BEEF; digit_en = 8'h5A; dp_in = 8'hC3;
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    load = 1'b1; value = 32'hFFFF_FFFF; digit_en = 8'hFF; dp_in = 8'hFF;
    tick(); tick(); tick();
    n_tests += 5;
    if (encoded !== 4'h0) begin n_fail++; $display("FAIL reset encoded got %h want 0", encoded); end
    if (anode !== 8'hFF) begin n_fail++; $display("FAIL reset anode got %h want ff", anode); end
    if (dp_n !== 1'b1) begin n_fail++; $display("FAIL reset dp_n got %b want 1", dp_n); end
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset frame_start got %b want 0", frame_start); end
    if (anode0 !== 8'hFF) begin n_fail++; $display("FAIL reset anode_blank0 got %h want ff", anode0); end
    Rst_n = 1'b1; load = 1'b0;
  endtask

  // Frame 0 blank (load during reset ignored); load set A; frame 1 shows A.
  task automatic test_basic();
    run_frame("blank_after_reset", 32'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0,
              5, 32'h7654_3210, 8'hFF, 8'h00);
    run_frame("basic", 32'h7654_3210, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1,
              3, 32'h89AB_CDEF, 8'hAA, 8'h08);
  endtask

  // Half the digits disabled plus a dp on digit 3; load lands on the exact copy edge.
  task automatic test_enable_dp_and_tc_load();
    run_frame("en_dp", 32'h89AB_CDEF, 8'hAA, 8'h08, 8'hFF, 8'h00, 1'b1,
              31, 32'hAAAA_AAAA, 8'hFF, 8'hFF);
    run_frame("tc_load_old", 32'h89AB_CDEF, 8'hAA, 8'h08, 8'hAA, 8'h08, 1'b1,
              -1, 32'h0, 8'h00, 8'h00);
    run_frame("tc_load_new", 32'hAAAA_AAAA, 8'hFF, 8'hFF, 8'hAA, 8'h08, 1'b1,
              -1, 32'h0, 8'h00, 8'h00);
  endtask

  task automatic test_reset_mid();
    load = 1'b1; value = 32'h1234_5678; digit_en = 8'hFF; dp_in = 8'h00;
    tick();
    load = 1'b0;
    for (int j = 1; j < 22; j++) tick();
    n_tests += 2;
    if (dut.cnt !== 2'd2 || dut.idx !== 3'd5) begin
      n_fail++; $display("FAIL mid_position got cnt=%0d idx=%0d want cnt=2 idx=5", dut.cnt, dut.idx);
    end
    if (anode !== 8'hDF) begin n_fail++; $display("FAIL mid_anode_before got %h want df", anode); end
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    n_tests += 5;
    if (anode !== 8'hFF) begin n_fail++; $display("FAIL mid_reset anode got %h want ff", anode); end
    if (encoded !== 4'h0) begin n_fail++; $display("FAIL mid_reset encoded got %h want 0", encoded); end
    if (dut.idx !== 3'd0) begin n_fail++; $display("FAIL mid_reset idx got %0d want 0", dut.idx); end
    if (dut.cnt !== 2'd0) begin n_fail++; $display("FAIL mid_reset cnt got %0d want 0", dut.cnt); end
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL mid_reset frame_start got %b want 0", frame_start); end
    run_frame("post_reset_f0", 32'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, -1, 32'h0, 8'h00, 8'h00);
    run_frame("post_reset_f1", 32'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1,
              10, 32'h0F1E_2D3C, 8'h3C, 8'h81);
    run_frame("reload", 32'h0F1E_2D3C, 8'h3C, 8'h81, 8'h00, 8'h00, 1'b1, -1, 32'h0, 8'h00, 8'h00);
  endtask

  initial begin
    Rst_n = 1'b0; load = 1'b0; value = 32'h0; digit_en = 8'h00; dp_in = 8'h00;
    test_reset();
    test_basic();
    test_enable_dp_and_tc_load();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/anode_scan.md
ANODE_SCAN -- requirements
Module: anode_scan

Parameters
REQ-001 REFRESH_DIV, 100000, Clk cycles per digit slot; legal range 2..2^20.
REQ-002 BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0..REFRESH_DIV-1.

Interface
REQ-003 Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of Clk.
REQ-005 value  input  32  eight hex nibbles; nibble k = value[4k+3:4k] is shown on digit k.
REQ-006 digit_en  input  8  per-digit enable; 0 blanks digit k.
REQ-007 dp_in  input  8  per-digit decimal point request, active-high.
REQ-008 load  input  1  single-cycle strobe; captures value/digit_en/dp_in into the pending set.
REQ-009 encoded  output  4  registered nibble for the downstream cathode decoder.
REQ-010 dp_n  output  1  registered decimal point, active-low, aligned with anode.
REQ-011 anode  output  8  registered digit selects, active-low; at most one bit low.
REQ-012 frame_start  output  1  one-cycle pulse on the edge the active set is refreshed.

Function
REQ-013 Slot counter cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; wrap edge = terminal count (TC).
REQ-014 Digit index idx (3 bits) SHALL increment on TC, wrapping 7 -> 0.
REQ-015 The block SHALL hold two register sets, pending and active, each of value/digit_en/dp_in.
REQ-016 load=1 SHALL write inputs to pending on that edge; load has no other effect.
REQ-017 On TC with idx==7, pending SHALL copy into active, and frame_start SHALL be 1 for the following cycle only.
REQ-018 Simultaneous load and copy: active receives the old pending; pending receives the new inputs (shown next frame).
REQ-019 encoded SHALL equal the active nibble selected by idx, registered on the same edge idx updates (i.e. computed from the next idx and next active set).
REQ-020 anode and dp_n SHALL be delayed exactly one cycle relative to encoded, matching the one-cycle registered cathode decoder downstream.
REQ-021 anode[k] SHALL be 0 only when delayed idx==k, delayed active digit_en[k]==1 and delayed cnt >= BLANK_CYCLES; otherwise 1.
REQ-022 dp_n SHALL be the inverse of delayed active dp_in[idx] during the same cycles anode is driven low, else 1.
REQ-023 Disabled digits SHALL still occupy their slot time (scan rate constant regardless of digit_en).
REQ-024 BLANK_CYCLES=0 SHALL drive the selected anode low for the whole slot (after the one-cycle alignment delay).

Reset
REQ-025 While Rst_n=0 at an edge: cnt=0, idx=0, pending and active sets all zero, encoded=4'h0, anode=8'hFF, dp_n=1, frame_start=0.
REQ-026 Reset asserted mid-slot or mid-frame SHALL abort the scan; first edge after release starts slot 0 with cnt=0.
REQ-027 load during reset SHALL be ignored.
REQ-028 After reset, display stays blank (digit_en active=0) until a load followed by a frame boundary.

Verification (REFRESH_DIV=4, BLANK_CYCLES=1 unless noted)
REQ-029 Reset then load value=32'h76543210, digit_en=8'hFF, dp_in=8'h00 -> after first frame_start, encoded steps 0,1,..,7 every 4 cycles; anode low bit follows one cycle later, high for first cycle of each slot; dp_n=1 throughout.
REQ-030 digit_en=8'b1010_1010 -> anode bits 0,2,4,6 never low; slot timing unchanged (32-cycle frame).
REQ-031 dp_in=8'h08 -> dp_n=0 only during digit-3 anode-low cycles.
REQ-032 load of 32'hAAAAAAAA on the exact TC edge with idx==7 -> that frame shows the previous pending value; next frame shows A on all digits.
REQ-033 Rst_n pulsed low at cnt=2, idx=5 -> next cycle anode=8'hFF, encoded=0, idx=0; display blank until reload and frame boundary.
REQ-034 BLANK_CYCLES=0 -> each enabled anode low for 4 consecutive cycles, never two anodes low simultaneously.
